// File: rtl/rast_tri_source.sv
// Triangle source for the rasterizer input: host pushes triangles into a FIFO,
// a single registered stage presents them under halt backpressure, and frames end with a drain.
module rast_tri_source #(
  parameter int SIGFIG       = 24,
  parameter int VERTS        = 3,
  parameter int AXIS         = 3,
  parameter int COLORS       = 3,
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 13
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    in_tri,
  input  logic [COLORS*SIGFIG-1:0]        in_color,
  input  logic                            in_eof,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_R10S,
  output logic [COLORS*SIGFIG-1:0]        color_R10U,
  output logic                            validTri_R10H,
  input  logic                            halt_RnnnnL,
  output logic                            frame_done,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_count
);

  localparam int TRI_W = VERTS*AXIS*SIGFIG;
  localparam int COL_W = COLORS*SIGFIG;
  localparam int ENT_W = TRI_W + COL_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES+1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DRN_W-1:0] drain_cnt;
  state_t           state;

  logic [TRI_W-1:0] tri_p1;
  logic [COL_W-1:0] color_p1;
  logic             vld_p1;
  logic             eof_p1;
  logic             done_p1;

  logic             push, pop, accept, fifo_empty;
  logic [ENT_W-1:0] head;

  assign in_ready   = !rst && (count < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign accept     = vld_p1 && halt_RnnnnL;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // An eof accept ends the frame, so it never refills the stage in the same cycle.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      STREAM:  pop = accept && !eof_p1 && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Stage 0: FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_eof, in_color, in_tri};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage 1: output register and frame sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tri_p1    <= '0;
      color_p1  <= '0;
      vld_p1    <= 1'b0;
      eof_p1    <= 1'b0;
      done_p1   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      done_p1 <= 1'b0;
      if (pop) begin
        tri_p1   <= head[TRI_W-1:0];
        color_p1 <= head[TRI_W +: COL_W];
        eof_p1   <= head[ENT_W-1];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state  <= STREAM;
            vld_p1 <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            if (eof_p1) begin
              state  <= DRAIN;
              vld_p1 <= 1'b0;
            end else if (fifo_empty) begin
              state  <= IDLE;
              vld_p1 <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Only advancing cycles move in-flight work through the rasterizer.
          if (halt_RnnnnL) begin
            if (drain_cnt == DRN_W'(DRAIN_CYCLES-1)) begin
              state   <= DONE;
              done_p1 <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DRN_W'(1);
            end
          end
        end
        DONE: begin
          drain_cnt <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tri_R10S      = tri_p1;
  assign color_R10U    = color_p1;
  assign validTri_R10H = vld_p1;
  assign frame_done    = done_p1;

endmodule

// File: tb/tb_rast_tri_source.sv
// Directed bench for rast_tri_source: a cycle table for streaming/backpressure,
// plus hand-written sequences for frame drain, halt toggling and mid-stream reset.
module tb_rast_tri_source;
  localparam int SIGFIG = 24, VERTS = 3, AXIS = 3, COLORS = 3, DEPTH = 8, DRAIN_CYCLES = 13;
  localparam int TRI_W = VERTS*AXIS*SIGFIG;
  localparam int COL_W = COLORS*SIGFIG;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [TRI_W-1:0]            in_tri;
  logic [COL_W-1:0]            in_color;
  logic                        in_eof;
  logic                        in_valid;
  logic                        in_ready;
  logic [TRI_W-1:0]            tri_R10S;
  logic [COL_W-1:0]            color_R10U;
  logic                        validTri_R10H;
  logic                        halt_RnnnnL;
  logic                        frame_done;
  logic [$clog2(DEPTH+1)-1:0]  fifo_count;

  rast_tri_source #(
    .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
    .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .in_tri(in_tri), .in_color(in_color), .in_eof(in_eof),
    .in_valid(in_valid), .in_ready(in_ready), .tri_R10S(tri_R10S), .color_R10U(color_R10U),
    .validTri_R10H(validTri_R10H), .halt_RnnnnL(halt_RnnnnL), .frame_done(frame_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        eof;
    logic        halt;
    logic [23:0] tv;
    logic        e_vld;
    logic [23:0] e_tv;
    int          e_cnt;
    logic        e_rdy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Triangle value tv is replicated over all coordinates; its color is tv-1 on each channel.
  task automatic drive(input logic v, input logic eof, input logic h, input logic [23:0] tv);
    in_valid    = v;
    in_eof      = eof;
    halt_RnnnnL = h;
    in_tri      = {9{tv}};
    in_color    = {3{tv - 24'd1}};
  endtask

  task automatic check_out(input string tag, input logic evld, input logic [23:0] etv,
                           input int ecnt, input logic erdy, input logic edone);
    logic [23:0] ecv;
    ecv = etv - 24'd1;
    chk({tag, ".vld"},  256'(validTri_R10H), 256'(evld));
    chk({tag, ".cnt"},  256'(fifo_count),    256'(ecnt));
    chk({tag, ".rdy"},  256'(in_ready),      256'(erdy));
    chk({tag, ".done"}, 256'(frame_done),    256'(edone));
    if (evld) begin
      chk({tag, ".tri"}, 256'(tri_R10S),   256'({9{etv}}));
      chk({tag, ".col"}, 256'(color_R10U), 256'({3{ecv}}));
    end
  endtask

  task automatic add(input logic v, input logic eof, input logic h, input logic [23:0] tv,
                     input logic evld, input logic [23:0] etv, input int ecnt,
                     input logic erdy, input logic edone);
    vec_t r;
    r.v = v; r.eof = eof; r.halt = h; r.tv = tv;
    r.e_vld = evld; r.e_tv = etv; r.e_cnt = ecnt; r.e_rdy = erdy; r.e_done = edone;
    vecs.push_back(r);
  endtask

  int seen;

  initial begin
    // Cycle table: each row drives one edge and states the outputs right after it.
    add(1'b1, 1'b0, 1'b1, 24'h400, 1'b0, 24'h0,   1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 24'h0,   1'b1, 24'h400, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 24'h0,   1'b0, 24'h0,   0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 24'h0,   1'b0, 24'h0,   0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 24'h10,  1'b0, 24'h0,   1, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++)
      add(1'b1, 1'b0, 1'b0, 24'(16 + k), 1'b1, 24'h10, k, k < 8, 1'b0);
    for (int k = 0; k < 10; k++)
      add(k == 0, 1'b0, 1'b0, 24'h19, 1'b1, 24'h10, 8, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++)
      add(1'b0, 1'b0, 1'b1, 24'h0, 1'b1, 24'(16 + k), 8 - k, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 24'h0, 0, 1'b1, 1'b0);

    drive(1'b0, 1'b0, 1'b1, 24'h0);
    rst = 1'b1;
    tick;
    chk("rst.vld",  256'(validTri_R10H), 256'(0));
    chk("rst.cnt",  256'(fifo_count),    256'(0));
    chk("rst.rdy",  256'(in_ready),      256'(0));
    chk("rst.done", 256'(frame_done),    256'(0));
    chk("rst.tri",  256'(tri_R10S),      256'(0));
    chk("rst.col",  256'(color_R10U),    256'(0));
    tick;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].eof, vecs[i].halt, vecs[i].tv);
      tick;
      check_out($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_tv, vecs[i].e_cnt,
                vecs[i].e_rdy, vecs[i].e_done);
    end

    // Three-triangle frame, fourth triangle pushed during the drain.
    drive(1'b1, 1'b0, 1'b1, 24'h20); tick; check_out("frm.a", 1'b0, 24'h0,  1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 24'h21); tick; check_out("frm.b", 1'b1, 24'h20, 1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 24'h22); tick; check_out("frm.c", 1'b1, 24'h21, 1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 24'h0);  tick; check_out("frm.d", 1'b1, 24'h22, 0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 24'h0);  tick; check_out("frm.e", 1'b0, 24'h0,  0, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) drive(1'b1, 1'b0, 1'b1, 24'h23);
      else        drive(1'b0, 1'b0, 1'b1, 24'h0);
      tick;
      check_out($sformatf("drn%0d", k), 1'b0, 24'h0, (k >= 2) ? 1 : 0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1, 24'h0);
    tick; check_out("frm.done",  1'b0, 24'h0,  1, 1'b1, 1'b1);
    tick; check_out("frm.idle",  1'b0, 24'h0,  1, 1'b1, 1'b0);
    tick; check_out("frm.load",  1'b1, 24'h23, 0, 1'b1, 1'b0);
    tick; check_out("frm.empty", 1'b0, 24'h0,  0, 1'b1, 1'b0);

    // Single-triangle frame drained with halt toggling.
    drive(1'b1, 1'b1, 1'b1, 24'h30); tick; check_out("tog.a", 1'b0, 24'h0,  1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 24'h0);  tick; check_out("tog.b", 1'b1, 24'h30, 0, 1'b1, 1'b0);
    tick; check_out("tog.c", 1'b0, 24'h0, 0, 1'b1, 1'b0);
    seen = 0;
    for (int j = 1; j <= 40 && seen == 0; j++) begin
      drive(1'b0, 1'b0, (j % 2) == 1, 24'h0);
      tick;
      if (frame_done) seen = j;
    end
    chk("tog.delay", 256'(seen), 256'(25));
    drive(1'b0, 1'b0, 1'b1, 24'h0);
    tick;
    chk("tog.pulse", 256'(frame_done), 256'(0));

    // Reset in the middle of a stalled stream with five entries queued.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 24'(64 + i));
      tick;
    end
    check_out("mid.q", 1'b1, 24'h40, 5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b1;
    tick;
    chk("mid.vld",  256'(validTri_R10H), 256'(0));
    chk("mid.tri",  256'(tri_R10S),      256'(0));
    chk("mid.col",  256'(color_R10U),    256'(0));
    chk("mid.cnt",  256'(fifo_count),    256'(0));
    chk("mid.rdy",  256'(in_ready),      256'(0));
    chk("mid.done", 256'(frame_done),    256'(0));
    rst = 1'b0;
    #1;
    chk("mid.rdy1", 256'(in_ready), 256'(1));
    drive(1'b1, 1'b0, 1'b1, 24'h50); tick; check_out("post.a", 1'b0, 24'h0,  1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 24'h0);  tick; check_out("post.b", 1'b1, 24'h50, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check_out($sformatf("post.c%0d", k), 1'b0, 24'h0, 0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rast_tri_source.md
Name: rast_tri_source

Overview:
- Transmit end of the rasterizer triangle-input interface. It buffers triangles pushed by the host or testbench in a FIFO and presents them one at a time as `tri_R10S`/`color_R10U` with `validTri_R10H`.
- It obeys the rasterizer's active-low `halt_RnnnnL` backpressure.
- It marks frame boundaries: after the last triangle of a frame it waits for the rasterizer pipe to drain, then pulses `frame_done`.

Parameters:
- SIGFIG, 24, bits per coordinate/color channel (from rast_params)
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels
- DEPTH, 8, FIFO entries (power of two, >=2)
- DRAIN_CYCLES, 13, advancing cycles waited after the last triangle of a frame (PIPES_BOX+PIPES_ITER+PIPES_HASH+PIPES_SAMP+4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_tri  in  VERTS*AXIS*SIGFIG  triangle vertices, flattened, vertex 0 axis 0 in LSBs
- in_color  in  COLORS*SIGFIG  triangle color
- in_eof  in  1  this triangle is last of frame
- in_valid  in  1  host push request
- in_ready  out  1  FIFO can accept
- tri_R10S  out  VERTS*AXIS*SIGFIG  triangle to rasterizer
- color_R10U  out  COLORS*SIGFIG  color to rasterizer
- validTri_R10H  out  1  output triangle valid
- halt_RnnnnL  in  1  0 = rasterizer stalled, 1 = advancing
- frame_done  out  1  one-cycle pulse, frame fully drained
- fifo_count  out  $clog2(DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, fifo_count=0, in_ready=0 while rst high, validTri_R10H=0, tri_R10S=0, color_R10U=0, frame_done=0, state=IDLE, drain counter=0. Reset mid-frame discards all buffered and in-flight triangles.
- Push: in_ready = !rst && (fifo_count < DEPTH), combinational from count only. A push occurs when in_valid && in_ready; the eof flag is stored with the entry. When full, a push in the same cycle as a pop is refused.
- Output stage: a single registered entry.
  - Accept = validTri_R10H && halt_RnnnnL.
  - While halt_RnnnnL=0, tri_R10S, color_R10U and validTri_R10H hold stable.
  - Load from FIFO head when (stage empty or accept) and FIFO non-empty and state is IDLE or STREAM. Pop in the same cycle.
  - Push-to-validTri latency on an empty block is 2 cycles: FIFO write, then stage load.
  - Back-to-back accepts sustain one triangle per cycle.
- Simultaneous push and pop in one cycle: fifo_count unchanged. Read and write pointers wrap modulo DEPTH.
- States:
  - IDLE: stage empty. Goes to STREAM on stage load.
  - STREAM: stage valid.
    - Accept of an eof-flagged triangle goes to DRAIN, clears validTri_R10H and does not load.
    - Accept of a non-eof triangle with FIFO empty goes to IDLE with validTri_R10H=0.
    - Otherwise stays in STREAM.
  - DRAIN: validTri_R10H=0, no loads, pushes still accepted. The counter increments only on cycles with halt_RnnnnL=1. When counter reaches DRAIN_CYCLES-1 on an advancing cycle, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, counter cleared, then go to IDLE. A load may occur in the cycle after DONE.
- The eof flag on a push with in_valid=0 is ignored.
- frame_done is registered, never asserted outside DONE.

Test Plan:
- Reset, push triangle A (in_tri all 0x000400 coordinates, color 0x3FF each), halt=1 → validTri_R10H rises 2 cycles after push, tri_R10S=A, accepted next cycle, validTri_R10H falls, state IDLE.
- Push 8 triangles with halt=0 → fifo_count climbs to 7 (one moves to stage), then 8 with a 9th push; in_ready=0 at count 8. A push attempted while full is refused and not stored; outputs hold stable through 10 stall cycles.
- Release halt after full FIFO → 9 triangles accepted on 9 consecutive cycles in push order, fifo_count returns to 0.
- Frame of 3 triangles, last with in_eof=1, halt=1 → after the third accept, validTri_R10H=0 for 13 cycles and frame_done pulses exactly once on the 14th cycle. A 4th triangle pushed during DRAIN issues only after DONE.
- DRAIN with halt toggling 1,0,1,0… → frame_done delayed to the 13th advancing cycle (about 26 cycles).
- Assert rst for 1 cycle mid-stream with 5 queued → all outputs 0, fifo_count=0, no frame_done; a new push afterwards behaves as after power-on.
